// File: rtl/out_register.sv
// N-bit capture register read out as 32-bit words, low word first, over a valid/re handshake.
// Optional sticky protocol-error flag enabled by defining OUT_REGISTER_ERR_EN.
module out_register #(
  parameter int C_NUM_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [C_NUM_BITS-1:0] din,
  input  logic                  load,
  output logic                  busy,
  output logic [31:0]           dout,
  output logic                  valid,
  input  logic                  re,
  output logic                  done,
`ifdef OUT_REGISTER_ERR_EN
  output logic                  err,
`endif
  output logic                  state_dbg
);

  localparam int C_NUM_WORDS  = (C_NUM_BITS + 31) / 32;
  localparam int C_COUNT_BITS = $clog2(C_NUM_WORDS);
  localparam int CW           = C_COUNT_BITS + 1;
  localparam int DW           = C_NUM_WORDS * 32;
  localparam logic [CW-1:0] LAST = CW'(C_NUM_WORDS - 1);

  // Handshake: a word transfers on any rising edge where valid && re.
  // load is only honoured while busy is low; valid/busy/done are registered.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [DW-1:0]  data;
  logic [DW-1:0]  din_ext;

  // Zero-extension also clears the unused top bits of the last word.
  always_comb begin
    din_ext = '0;
    din_ext[C_NUM_BITS-1:0] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            data  <= din_ext;
            count <= '0;
            state <= SEND;
            busy  <= 1'b1;
            valid <= 1'b1;
          end
        end
        SEND: begin
          if (re) begin
            if (count == LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              valid <= 1'b0;
              count <= '0;
              done  <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    if (valid) dout = data[int'(count)*32 +: 32];
  end

  assign state_dbg = (state == SEND);

`ifdef OUT_REGISTER_ERR_EN
  // Sticky until reset: a load while busy or a read with nothing to read.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((load && busy) || (re && !valid)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_out_register.sv
// Directed + random bench for out_register at widths 72 (3 words) and 32 (1 word),
// compared against a word-queue reference model.
module tb_out_register;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] din_a = '0;
  logic        load_a = 1'b0, re_a = 1'b0;
  logic        busy_a, valid_a, done_a, sd_a;
  logic [31:0] dout_a;
  logic [31:0] din_b = '0;
  logic        load_b = 1'b0, re_b = 1'b0;
  logic        busy_b, valid_b, done_b, sd_b;
  logic [31:0] dout_b;
`ifdef OUT_REGISTER_ERR_EN
  logic        err_a, err_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining words per instance, plus done/err flags.
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  logic        m_done_a = 1'b0, m_done_b = 1'b0;
  logic        m_err_a = 1'b0, m_err_b = 1'b0;

  always #5 clk = ~clk;

  out_register #(.C_NUM_BITS(72)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .load(load_a), .busy(busy_a),
    .dout(dout_a), .valid(valid_a), .re(re_a), .done(done_a),
`ifdef OUT_REGISTER_ERR_EN
    .err(err_a),
`endif
    .state_dbg(sd_a)
  );

  out_register #(.C_NUM_BITS(32)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .load(load_b), .busy(busy_b),
    .dout(dout_b), .valid(valid_b), .re(re_b), .done(done_b),
`ifdef OUT_REGISTER_ERR_EN
    .err(err_b),
`endif
    .state_dbg(sd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e;
    e = (exp_q_a.size() != 0) ? exp_q_a[0] : 32'h0;
    check("a_busy",  32'(busy_a),  32'(exp_q_a.size() != 0));
    check("a_valid", 32'(valid_a), 32'(exp_q_a.size() != 0));
    check("a_dout",  dout_a, e);
    check("a_done",  32'(done_a),  32'(m_done_a));
    e = (exp_q_b.size() != 0) ? exp_q_b[0] : 32'h0;
    check("b_busy",  32'(busy_b),  32'(exp_q_b.size() != 0));
    check("b_valid", 32'(valid_b), 32'(exp_q_b.size() != 0));
    check("b_dout",  dout_b, e);
    check("b_done",  32'(done_b),  32'(m_done_b));
`ifdef OUT_REGISTER_ERR_EN
    check("a_err", 32'(err_a), 32'(m_err_a));
    check("b_err", 32'(err_b), 32'(m_err_b));
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check on the falling edge.
  task automatic step(input logic r, input logic la, input logic ra, input logic [71:0] da,
                      input logic lb, input logic rb, input logic [31:0] db);
    logic bsy;
    rst = r; load_a = la; re_a = ra; din_a = da; load_b = lb; re_b = rb; din_b = db;
    @(posedge clk);
    if (r) begin
      exp_q_a.delete(); exp_q_b.delete();
      m_done_a = 1'b0; m_done_b = 1'b0; m_err_a = 1'b0; m_err_b = 1'b0;
    end else begin
      bsy = (exp_q_a.size() != 0);
      if ((la && bsy) || (ra && !bsy)) m_err_a = 1'b1;
      m_done_a = bsy && ra && (exp_q_a.size() == 1);
      if (bsy && ra) void'(exp_q_a.pop_front());
      else if (!bsy && la)
        for (int i = 0; i < 3; i++) exp_q_a.push_back(32'(da >> (32 * i)));
      bsy = (exp_q_b.size() != 0);
      if ((lb && bsy) || (rb && !bsy)) m_err_b = 1'b1;
      m_done_b = bsy && rb;
      if (bsy && rb) void'(exp_q_b.pop_front());
      else if (!bsy && lb) exp_q_b.push_back(db);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic step_a(input logic la, input logic ra, input logic [71:0] da);
    step(1'b0, la, ra, da, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [71:0] rv;
    // Reset.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    // Three-word readout with re held high.
    step_a(1'b1, 1'b0, 72'hAB_12345678_9ABCDEF0);
    step_a(1'b0, 1'b1, '0);
    step_a(1'b0, 1'b1, '0);
    step_a(1'b0, 1'b1, '0);
    step_a(1'b0, 1'b0, '0);

    // All-ones value, re pulsed every other cycle.
    step_a(1'b1, 1'b0, 72'h00_00FFFFFF_FFFFFFFF);
    for (int i = 0; i < 7; i++) step_a(1'b0, i[0], '0);
    step_a(1'b1, 1'b0, 72'hFF_FFFFFFFF_FFFFFFFF);
    for (int i = 0; i < 7; i++) step_a(1'b0, i[0], '0);

    // Load while busy is ignored, including alongside the final read.
    step_a(1'b1, 1'b0, 72'h11_22222222_33333333);
    step_a(1'b0, 1'b1, '0);
    step_a(1'b1, 1'b0, 72'h44_55555555_66666666);
    step_a(1'b0, 1'b1, '0);
    step_a(1'b1, 1'b1, 72'h77_88888888_99999999);
    step_a(1'b1, 1'b0, 72'hCC_DDDDDDDD_EEEEEEEE);
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, '0);

    // Single-word back-to-back with reload in the done cycle.
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h01234567);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    // Reset mid-transfer, then a fresh load.
    step_a(1'b1, 1'b0, 72'h01_02030405_06070809);
    step_a(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    step_a(1'b0, 1'b0, '0);
    step_a(1'b1, 1'b0, 72'hA5_5A5A5A5A_C3C3C3C3);
    for (int i = 0; i < 4; i++) step_a(1'b0, 1'b1, '0);

    // Read in IDLE after reset, on both instances.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rv = {8'($urandom), $urandom, $urandom};
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), rv,
           $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
